// File: rtl/mig_app_pkg.sv
// Shared types for the MIG app-interface responder: command encodings and FIFO entry layouts.
// Entry fields are sized for the default 128-bit / 1024-word configuration and zero-extended otherwise.
package mig_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int unsigned ENTRY_IDX_W  = 26;
    localparam int unsigned ENTRY_DATA_W = 128;
    localparam int unsigned ENTRY_MASK_W = 16;

    typedef enum logic [2:0] {
        APP_CMD_WRITE = CMD_WRITE,
        APP_CMD_READ  = CMD_READ
    } app_cmd_t;

    typedef struct packed {
        app_cmd_t                 cmd;
        logic [ENTRY_IDX_W-1:0]   idx;
    } cmd_entry_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0]  data;
        logic [ENTRY_MASK_W-1:0]  mask;
    } wdf_entry_t;

endpackage

// File: rtl/mig_app_if.sv
// MIG 7-series user (app_*) interface bundle; master is the requester, slave is the memory side.
interface mig_app_if #(
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;
    logic                  init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete
    );
endinterface

// File: rtl/app_sync_fifo.sv
// Single-clock FIFO with registered storage; a push becomes visible on dout_o the following cycle.
module app_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the MIG UI: command and write-data FIFOs, in-order execute stage,
// byte-masked word memory and a fixed-latency read return pipeline.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 29,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned RD_LATENCY   = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CALIB_CYCLES = 16,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic       clk,
    input  logic       rst,
    mig_app_if.slave   app
);
    localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned COL_W   = ADDR_WIDTH - 3;
    localparam int unsigned SP      = (STALL_PERIOD == 0) ? 1 : STALL_PERIOD;
    localparam int unsigned STALL_W = $clog2(SP + 1);
    localparam int unsigned CAL_W   = $clog2(CALIB_CYCLES + 2);

    typedef enum logic [0:0] {
        ST_CALIB = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               state_q;
    logic [CAL_W-1:0]     calib_cnt_q;
    logic                 calib_done_q;
    logic [STALL_W-1:0]   stall_cnt_q;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

    logic                  run_s, stall_s, cmd_rdy_s, wdf_rdy_s;
    logic                  cmd_push_s, wdf_push_s, cmd_pop_s, wdf_pop_s;
    logic                  cmd_full_s, cmd_empty_s, wdf_full_s, wdf_empty_s;
    logic                  rd_issue_s, wr_exec_s;
    logic [COL_W-1:0]      col_s, mod_s;
    logic [IDX_W-1:0]      idx_s, head_idx_s;
    cmd_entry_t            cmd_din_s, cmd_head_s;
    wdf_entry_t            wdf_din_s, wdf_head_s;
    logic                  unused_s;

    // Bytes whose mask bit is set keep their previous contents.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [MASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < int'(MASK_WIDTH); b++) begin
            merged[b*8 +: 8] = mask[b] ? old_word[b*8 +: 8] : new_word[b*8 +: 8];
        end
        return merged;
    endfunction

    assign run_s     = (state_q == ST_RUN);
    assign stall_s   = (STALL_PERIOD != 0) && run_s && (stall_cnt_q == STALL_W'(SP - 1));
    assign cmd_rdy_s = run_s && !cmd_full_s && !stall_s;
    assign wdf_rdy_s = run_s && !wdf_full_s;

    assign cmd_push_s = app.app_en && cmd_rdy_s;
    assign wdf_push_s = app.app_wdf_wren && wdf_rdy_s;

    // app_addr counts columns; one stored word covers a BL8 burst of eight columns.
    assign col_s     = app.app_addr[ADDR_WIDTH-1:3];
    assign mod_s     = col_s % COL_W'(MEM_DEPTH);
    assign idx_s     = IDX_W'(mod_s);
    assign cmd_din_s = '{cmd: app_cmd_t'(app.app_cmd), idx: ENTRY_IDX_W'(idx_s)};
    assign wdf_din_s = '{data: ENTRY_DATA_W'(app.app_wdf_data), mask: ENTRY_MASK_W'(app.app_wdf_mask)};
    assign head_idx_s = cmd_head_s.idx[IDX_W-1:0];

    assign unused_s = ^{app.app_wdf_end, app.app_addr[2:0], mod_s, cmd_head_s, wdf_head_s};

    app_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_push_s),
        .din_i   (cmd_din_s),
        .pop_i   (cmd_pop_s),
        .dout_o  (cmd_head_s),
        .full_o  (cmd_full_s),
        .empty_o (cmd_empty_s)
    );

    app_sync_fifo #(.WIDTH($bits(wdf_entry_t)), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wdf_push_s),
        .din_i   (wdf_din_s),
        .pop_i   (wdf_pop_s),
        .dout_o  (wdf_head_s),
        .full_o  (wdf_full_s),
        .empty_o (wdf_empty_s)
    );

    // Execute stage: retire the head command; a write without data blocks everything behind it.
    always_comb begin
        cmd_pop_s  = 1'b0;
        wdf_pop_s  = 1'b0;
        rd_issue_s = 1'b0;
        wr_exec_s  = 1'b0;
        if (!cmd_empty_s) begin
            case (cmd_head_s.cmd)
                APP_CMD_READ: begin
                    rd_issue_s = 1'b1;
                    cmd_pop_s  = 1'b1;
                end
                APP_CMD_WRITE: begin
                    if (!wdf_empty_s) begin
                        wr_exec_s = 1'b1;
                        cmd_pop_s = 1'b1;
                        wdf_pop_s = 1'b1;
                    end else begin
                        wr_exec_s = 1'b0;
                    end
                end
                default: begin
                    cmd_pop_s = 1'b1;
                end
            endcase
        end else begin
            cmd_pop_s = 1'b0;
        end
    end

    // Calibration / run state machine with the stall cadence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CALIB;
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_CALIB: begin
                    if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                        state_q      <= ST_RUN;
                        calib_done_q <= 1'b1;
                    end else begin
                        calib_cnt_q  <= calib_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stall_cnt_q == STALL_W'(SP - 1)) begin
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_CALIB;
                    calib_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Word memory survives rst so data written before a reset can be read back afterwards.
    always_ff @(posedge clk) begin
        if (wr_exec_s) begin
            mem_q[head_idx_s] <= merge_bytes(mem_q[head_idx_s],
                                             wdf_head_s.data[DATA_WIDTH-1:0],
                                             wdf_head_s.mask[MASK_WIDTH-1:0]);
        end
    end

    // Read return pipeline; the last stage drives the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int s = 0; s < int'(RD_LATENCY); s++) begin
                pipe_data_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd_issue_s;
            pipe_data_q[0] <= rd_issue_s ? mem_q[head_idx_s] : '0;
            for (int s = 1; s < int'(RD_LATENCY); s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_data_q[s] <= pipe_data_q[s-1];
            end
        end
    end

    assign app.app_rdy             = cmd_rdy_s;
    assign app.app_wdf_rdy         = wdf_rdy_s;
    assign app.app_rd_data         = pipe_data_q[RD_LATENCY-1];
    assign app.app_rd_data_valid   = pipe_vld_q[RD_LATENCY-1];
    assign app.app_rd_data_end     = pipe_vld_q[RD_LATENCY-1];
    assign app.init_calib_complete = calib_done_q;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: a queue-based transaction model checks every read return,
// and directed checks pin calibration timing, latency, masking, ordering, backpressure and reset.
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int RD_LAT = 4;
    localparam logic [127:0] D1   = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] ONES = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] MSKR = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;
    localparam logic [127:0] D2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D3   = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F1E_2D3C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mig_app_if #(.ADDR_WIDTH(29), .DATA_WIDTH(128), .MASK_WIDTH(16)) m ();
    mig_app_if #(.ADDR_WIDTH(29), .DATA_WIDTH(128), .MASK_WIDTH(16)) s ();

    mig_app_responder #(.ADDR_WIDTH(29), .DATA_WIDTH(128), .MASK_WIDTH(16), .MEM_DEPTH(1024),
        .RD_LATENCY(RD_LAT), .FIFO_DEPTH(4), .CALIB_CYCLES(16), .STALL_PERIOD(0))
        dut (.clk(clk), .rst(rst), .app(m));

    mig_app_responder #(.ADDR_WIDTH(29), .DATA_WIDTH(128), .MASK_WIDTH(16), .MEM_DEPTH(1024),
        .RD_LATENCY(RD_LAT), .FIFO_DEPTH(4), .CALIB_CYCLES(16), .STALL_PERIOD(8))
        dut_stall (.clk(clk), .rst(rst), .app(s));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct { int cyc; logic [2:0] cmd; int idx; } mcmd_t;
    typedef struct { int cyc; logic [127:0] data; logic [15:0] mask; } mwdf_t;
    typedef struct { int due; logic [127:0] data; } mexp_t;

    mcmd_t cq[$];
    mwdf_t wq[$];
    mexp_t eq[$];
    logic [127:0] mmem [int];
    int  cyc    = 0;
    bit  chk_en = 1'b0;

    function automatic logic [127:0] mrd(input int idx);
        return mmem.exists(idx) ? mmem[idx] : 128'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cq.delete();
            wq.delete();
            eq.delete();
        end else begin
            if (cq.size() > 0 && cq[0].cyc < cyc) begin
                if (cq[0].cmd == CMD_READ) begin
                    eq.push_back('{due: cyc + RD_LAT, data: mrd(cq[0].idx)});
                    void'(cq.pop_front());
                end else if (cq[0].cmd == CMD_WRITE) begin
                    if (wq.size() > 0 && wq[0].cyc < cyc) begin
                        logic [127:0] w;
                        w = mrd(cq[0].idx);
                        for (int b = 0; b < 16; b++) begin
                            if (!wq[0].mask[b]) w[b*8 +: 8] = wq[0].data[b*8 +: 8];
                        end
                        mmem[cq[0].idx] = w;
                        void'(cq.pop_front());
                        void'(wq.pop_front());
                    end
                end else begin
                    void'(cq.pop_front());
                end
            end
            if (m.app_en && m.app_rdy)
                cq.push_back('{cyc: cyc, cmd: m.app_cmd, idx: int'(m.app_addr >> 3) % 1024});
            if (m.app_wdf_wren && m.app_wdf_rdy)
                wq.push_back('{cyc: cyc, data: m.app_wdf_data, mask: m.app_wdf_mask});
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            ev = (eq.size() > 0 && eq[0].due == cyc);
            chk("model valid", {127'd0, m.app_rd_data_valid}, {127'd0, ev});
            chk("model end", {127'd0, m.app_rd_data_end}, {127'd0, ev});
            if (ev) chk("model data", m.app_rd_data, eq[0].data);
            while (eq.size() > 0 && eq[0].due <= cyc) void'(eq.pop_front());
        end
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
        int n = 0;
        m.app_en = 1'b1; m.app_cmd = c; m.app_addr = a;
        while (!m.app_rdy && n < 200) begin @(negedge clk); n++; end
        chk("cmd accept", {127'd0, m.app_rdy}, 128'd1);
        @(negedge clk);
        m.app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [127:0] d, input logic [15:0] mk);
        int n = 0;
        m.app_wdf_wren = 1'b1; m.app_wdf_data = d; m.app_wdf_mask = mk;
        while (!m.app_wdf_rdy && n < 200) begin @(negedge clk); n++; end
        chk("wdf accept", {127'd0, m.app_wdf_rdy}, 128'd1);
        @(negedge clk);
        m.app_wdf_wren = 1'b0;
    endtask

    task automatic send_both(input logic [28:0] a, input logic [127:0] d, input logic [15:0] mk);
        int n = 0;
        m.app_en = 1'b1; m.app_cmd = CMD_WRITE; m.app_addr = a;
        m.app_wdf_wren = 1'b1; m.app_wdf_data = d; m.app_wdf_mask = mk;
        while (!(m.app_rdy && m.app_wdf_rdy) && n < 200) begin @(negedge clk); n++; end
        chk("both accept", {127'd0, m.app_rdy && m.app_wdf_rdy}, 128'd1);
        @(negedge clk);
        m.app_en = 1'b0; m.app_wdf_wren = 1'b0;
    endtask

    task automatic wait_read(input string nm, input logic [127:0] exp, output int waited);
        int n = 0;
        while (!m.app_rd_data_valid && n < 60) begin @(negedge clk); n++; end
        waited = n;
        chk({nm, " valid"}, {127'd0, m.app_rd_data_valid}, 128'd1);
        chk({nm, " data"}, m.app_rd_data, exp);
    endtask

    function automatic logic [127:0] bp_data(input int i);
        logic [31:0] w;
        w = 32'hB000_0000 + 32'(i);
        return {w, w, w, w};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int lat, vcnt, lows;
        int low_at[$];
        m.app_en = 1'b0; m.app_cmd = 3'b000; m.app_addr = 29'd0;
        m.app_wdf_data = 128'd0; m.app_wdf_mask = 16'd0; m.app_wdf_wren = 1'b0; m.app_wdf_end = 1'b1;
        s.app_en = 1'b0; s.app_cmd = 3'b000; s.app_addr = 29'd0;
        s.app_wdf_data = 128'd0; s.app_wdf_mask = 16'd0; s.app_wdf_wren = 1'b0; s.app_wdf_end = 1'b1;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst app_rdy", {127'd0, m.app_rdy}, 128'd0);
        chk("rst app_wdf_rdy", {127'd0, m.app_wdf_rdy}, 128'd0);
        chk("rst rd_valid", {127'd0, m.app_rd_data_valid}, 128'd0);
        chk("rst rd_end", {127'd0, m.app_rd_data_end}, 128'd0);
        chk("rst rd_data", m.app_rd_data, 128'd0);
        chk("rst calib", {127'd0, m.init_calib_complete}, 128'd0);
        rst = 1'b0;

        // calibration: low through cycle 15, high from cycle 16
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("calib rdy c%0d", k), {127'd0, m.app_rdy}, {127'd0, k == 16});
            chk($sformatf("calib done c%0d", k), {127'd0, m.init_calib_complete}, {127'd0, k == 16});
        end

        // write then read, latency 1 + RD_LAT from acceptance
        send_both(29'h40, D1, 16'h0000);
        send_cmd(CMD_READ, 29'h40);
        wait_read("wr_rd", D1, lat);
        chk("rd latency", 128'(lat + 1), 128'd5);
        chk("rd end", {127'd0, m.app_rd_data_end}, 128'd1);

        // mask and column alias within the same burst
        send_both(29'h80, ONES, 16'h0000);
        send_both(29'h87, 128'd0, 16'hFFFE);
        send_cmd(CMD_READ, 29'h80);
        wait_read("mask", MSKR, lat);

        // data ahead of its command
        send_wdf(D2, 16'h0000);
        repeat (2) @(negedge clk);
        send_cmd(CMD_WRITE, 29'h100);
        send_cmd(CMD_READ, 29'h100);
        wait_read("early data", D2, lat);

        // write command without data blocks the following read
        send_cmd(CMD_WRITE, 29'h100);
        send_cmd(CMD_READ, 29'h100);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m.app_rd_data_valid) vcnt++;
        end
        chk("stalled read", 128'(vcnt), 128'd0);
        send_wdf(D3, 16'h0000);
        wait_read("late data", D3, lat);

        // back-to-back reads return back-to-back
        m.app_en = 1'b1; m.app_cmd = CMD_READ;
        m.app_addr = 29'h40;  chk("b2b rdy0", {127'd0, m.app_rdy}, 128'd1); @(negedge clk);
        m.app_addr = 29'h80;  chk("b2b rdy1", {127'd0, m.app_rdy}, 128'd1); @(negedge clk);
        m.app_addr = 29'h100; chk("b2b rdy2", {127'd0, m.app_rdy}, 128'd1); @(negedge clk);
        m.app_en = 1'b0;
        wait_read("b2b0", D1, lat);
        @(negedge clk);
        chk("b2b1 valid", {127'd0, m.app_rd_data_valid}, 128'd1);
        chk("b2b1 data", m.app_rd_data, MSKR);
        @(negedge clk);
        chk("b2b2 valid", {127'd0, m.app_rd_data_valid}, 128'd1);
        chk("b2b2 data", m.app_rd_data, D3);

        // backpressure: four data-less writes fill the command FIFO
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send_cmd(CMD_WRITE, 29'h200 + 29'(i * 8));
        m.app_en = 1'b1; m.app_cmd = CMD_WRITE; m.app_addr = 29'h240;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp rdy low %0d", k), {127'd0, m.app_rdy}, 128'd0);
            @(negedge clk);
        end
        chk("bp wdf_rdy", {127'd0, m.app_wdf_rdy}, 128'd1);
        send_wdf(bp_data(0), 16'h0000);
        chk("bp rdy while pop", {127'd0, m.app_rdy}, 128'd0);
        @(negedge clk);
        chk("bp rdy back", {127'd0, m.app_rdy}, 128'd1);
        @(negedge clk);
        m.app_en = 1'b0;
        for (int i = 1; i < 5; i++) send_wdf(bp_data(i), 16'h0000);
        send_cmd(CMD_READ, 29'h200);
        wait_read("bp first", bp_data(0), lat);
        send_cmd(CMD_READ, 29'h240);
        wait_read("bp fifth", bp_data(4), lat);

        // stall cadence on the STALL_PERIOD=8 instance
        lows = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!s.app_rdy) begin lows++; low_at.push_back(k); end
        end
        chk("stall count", 128'(lows), 128'd4);
        for (int i = 1; i < low_at.size(); i++)
            chk($sformatf("stall spacing %0d", i), 128'(low_at[i] - low_at[i-1]), 128'd8);

        // reset with three reads in flight
        m.app_en = 1'b1; m.app_cmd = CMD_READ;
        m.app_addr = 29'h40;  @(negedge clk);
        m.app_addr = 29'h80;  @(negedge clk);
        m.app_addr = 29'h200; @(negedge clk);
        m.app_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (m.app_rd_data_valid) vcnt++;
            @(negedge clk);
        end
        chk("no valid after rst", 128'(vcnt), 128'd0);
        chk("recal done", {127'd0, m.init_calib_complete}, 128'd1);
        send_cmd(CMD_READ, 29'h40);
        wait_read("kept 0x40", D1, lat);
        send_cmd(CMD_READ, 29'h80);
        wait_read("kept 0x80", MSKR, lat);
        send_cmd(CMD_READ, 29'h200);
        wait_read("kept 0x200", bp_data(0), lat);
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
